pred_update_ctrl: RTL

PRED_UPDATE_CTRL -- requirements
Module: pred_update_ctrl

---
 rtl/pred_update_ctrl_pkg.sv | 40 ++++
 rtl/pred_update_ctrl_if.sv | 46 ++++
 rtl/pred_update_ctrl_fifo.sv | 64 ++++++
 rtl/pred_update_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pred_update_ctrl_pkg.sv
// Shared branch-predictor package: table geometry defaults, 2-bit counter
// encodings, tag-width helper and the resolved-branch queue entry.
package bp_pkg;

  localparam int IDX_BITS_DEF   = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  // 2-bit saturating counter encodings
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } upd_state_e;

  // The PC word address is 30 bits; whatever the index does not use is tag.
  function automatic int tag_width(input int idx_bits);
    return 30 - idx_bits;
  endfunction

  // Tag and index are kept joined as the PC word address because the split
  // point depends on the instantiating module's IDX_BITS.
  typedef struct packed {
    logic [29:0] tag_idx;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;

  // Next counter value after an outcome, pinned at both ends.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pred_update_ctrl_if.sv
// Resolve-bus and PHT/BTB write-port bundle for the predictor update controller.
// The controller is the slave; MEM plus the table memories form the master side.
interface pred_update_ctrl_if
  import bp_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF
);

  localparam int TAG_BITS = tag_width(IDX_BITS);

  logic                RES_VALID;
  logic                RES_READY;
  logic [31:0]         RES_PC;
  logic                RES_TAKEN;
  logic [31:0]         RES_TARGET;

  logic [IDX_BITS-1:0] PHT_RIDX;
  logic [1:0]          PHT_RDATA;
  logic                PHT_WE;
  logic [IDX_BITS-1:0] PHT_WIDX;
  logic [1:0]          PHT_WDATA;

  logic                BTB_WE;
  logic [IDX_BITS-1:0] BTB_WIDX;
  logic                BTB_WVALID;
  logic [TAG_BITS-1:0] BTB_WTAG;
  logic [31:0]         BTB_WTARGET;

  logic                PRED_EN;
  logic [31:0]         UPD_CNT;

  modport slave (
    input  RES_VALID, RES_PC, RES_TAKEN, RES_TARGET, PHT_RDATA,
    output RES_READY, PHT_RIDX, PHT_WE, PHT_WIDX, PHT_WDATA,
           BTB_WE, BTB_WIDX, BTB_WVALID, BTB_WTAG, BTB_WTARGET,
           PRED_EN, UPD_CNT
  );

  modport master (
    output RES_VALID, RES_PC, RES_TAKEN, RES_TARGET, PHT_RDATA,
    input  RES_READY, PHT_RIDX, PHT_WE, PHT_WIDX, PHT_WDATA,
           BTB_WE, BTB_WIDX, BTB_WVALID, BTB_WTAG, BTB_WTARGET,
           PRED_EN, UPD_CNT
  );

endinterface

// File: rtl/pred_update_ctrl_fifo.sv
// Small synchronous FIFO of resolved-branch updates. The head entry is
// visible combinationally so the controller can build its table writes from it.
module pred_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  upd_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output upd_entry_t head
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  upd_entry_t          mem_q [DEPTH];
  upd_entry_t          mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_BITS'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_BITS'(pop_ok);
    count_d  = count_q + CNT_BITS'(push_ok) - CNT_BITS'(pop_ok);
  end

  // Entry storage needs no reset; only occupancy decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pred_update_ctrl.sv
// Branch-predictor update controller: after reset it sweeps every PHT/BTB
// entry to a known state, then drains resolved branches from a queue into
// read-modify-write PHT updates and BTB allocations on taken branches.
module pred_update_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_BITS   = IDX_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  pred_update_ctrl_if.slave  bus
);

  localparam int                  TAG_BITS = tag_width(IDX_BITS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  upd_state_e          state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;
  logic [IDX_BITS-1:0] ridx_q, ridx_d;
  logic [31:0]         upd_cnt_q, upd_cnt_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  upd_entry_t          push_entry;
  upd_entry_t          head;
  logic [IDX_BITS-1:0] head_idx;
  logic [TAG_BITS-1:0] head_tag;

  logic                in_init;
  logic                in_idle;
  logic                res_ready;
  logic [IDX_BITS-1:0] pht_ridx;
  logic                pht_we;
  logic [IDX_BITS-1:0] pht_widx;
  logic [1:0]          pht_wdata;
  logic                btb_we;
  logic [IDX_BITS-1:0] btb_widx;
  logic                btb_wvalid;
  logic [TAG_BITS-1:0] btb_wtag;
  logic [31:0]         btb_wtarget;

  // While RESET is held low the outputs already look like the first sweep
  // cycle, so nothing downstream sees a stale update during reset.
  assign in_init   = !RESET || (state_q == ST_INIT);
  assign in_idle   = RESET && (state_q == ST_IDLE);
  assign res_ready = in_idle && !fifo_full;
  assign push      = bus.RES_VALID && res_ready;
  assign pop       = in_idle && !fifo_empty;

  assign push_entry = '{tag_idx: bus.RES_PC[31:2],
                        taken:   bus.RES_TAKEN,
                        target:  bus.RES_TARGET};
  assign head_idx   = head.tag_idx[IDX_BITS-1:0];
  assign head_tag   = head.tag_idx[29:IDX_BITS];

  pred_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // State, sweep counter, held read index and update counter registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      ridx_q    <= '0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      ridx_q    <= ridx_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  // Sweep one index per cycle and leave INIT after the last index is written.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ridx_d  = ridx_q;
    upd_cnt_d = upd_cnt_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pop) begin
          ridx_d    = head_idx;
          upd_cnt_d = upd_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Table write ports: sweep pattern in INIT, otherwise the queue head update.
  always_comb begin
    pht_ridx    = ridx_q;
    pht_we      = 1'b0;
    pht_widx    = '0;
    pht_wdata   = CTR_WNT;
    btb_we      = 1'b0;
    btb_widx    = '0;
    btb_wvalid  = 1'b0;
    btb_wtag    = '0;
    btb_wtarget = '0;
    if (in_init) begin
      pht_we   = 1'b1;
      pht_widx = RESET ? sweep_q : '0;
      btb_we   = 1'b1;
      btb_widx = RESET ? sweep_q : '0;
    end else if (pop) begin
      pht_ridx    = head_idx;
      pht_we      = 1'b1;
      pht_widx    = head_idx;
      pht_wdata   = sat_update(bus.PHT_RDATA, head.taken);
      btb_we      = head.taken;
      btb_widx    = head_idx;
      btb_wvalid  = 1'b1;
      btb_wtag    = head_tag;
      btb_wtarget = head.target;
    end
  end

  assign bus.RES_READY   = res_ready;
  assign bus.PHT_RIDX    = pht_ridx;
  assign bus.PHT_WE      = pht_we;
  assign bus.PHT_WIDX    = pht_widx;
  assign bus.PHT_WDATA   = pht_wdata;
  assign bus.BTB_WE      = btb_we;
  assign bus.BTB_WIDX    = btb_widx;
  assign bus.BTB_WVALID  = btb_wvalid;
  assign bus.BTB_WTAG    = btb_wtag;
  assign bus.BTB_WTARGET = btb_wtarget;
  assign bus.PRED_EN     = in_idle;
  assign bus.UPD_CNT     = upd_cnt_q;

endmodule
